// File: rtl/mouse_event_bridge_pkg.sv
// mouse_event_bridge_pkg
// Shared definitions for the mouse event bridge: register window layout,
// CTRL and LEVEL bit positions, and the queued packet format.
// Build option: MOUSE_WHEEL_EN adds a wheel (Z) byte to every queued packet.
package mouse_event_bridge_pkg;

    localparam int WINDOW_SIZE = 8;

    localparam logic [2:0] OFS_STATUS = 3'd0;
    localparam logic [2:0] OFS_X      = 3'd1;
    localparam logic [2:0] OFS_Y      = 3'd2;
    localparam logic [2:0] OFS_LEVEL  = 3'd3;
    localparam logic [2:0] OFS_CTRL   = 3'd4;
    localparam logic [2:0] OFS_POP    = 3'd5;
    localparam logic [2:0] OFS_WHEEL  = 3'd6;
    localparam logic [2:0] OFS_RSVD   = 3'd7;

    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_CLR_OVF = 2;

    localparam int LEVEL_OVF_BIT = 7;
    localparam int LEVEL_CNT_W   = 5;

    typedef struct packed {
`ifdef MOUSE_WHEEL_EN
        logic [7:0] z;
`endif
        logic [7:0] status;
        logic [7:0] x;
        logic [7:0] y;
    } pkt_t;

    localparam int PKT_W = $bits(pkt_t);

    function automatic logic [7:0] level_byte(input logic ovf, input logic [LEVEL_CNT_W-1:0] cnt);
        return {ovf, 2'b00, cnt};
    endfunction

    // Only IRQ_EN is stored; FLUSH and CLR_OVF are strobes and read back 0.
    function automatic logic [7:0] ctrl_byte(input logic irq_en);
        logic [7:0] b;
        b = '0;
        b[CTRL_IRQ_EN] = irq_en;
        return b;
    endfunction

endpackage

// File: rtl/mouse_event_bridge_if.sv
// mouse_event_bridge_if
// CPU-side bus of the mouse event bridge.
//   BUS_ADDR            8  address
//   BUS_DATA            8  shared tristate data (CPU drives on writes, bridge on reads)
//   BUS_WE              1  1 = write cycle
//   BUS_INTERRUPT_RAISE 1  interrupt request to CPU
//   BUS_INTERRUPT_ACK   1  interrupt acknowledge from CPU
// master = CPU side, slave = bridge side.
interface mouse_event_bridge_if;
    logic [7:0] BUS_ADDR;
    wire  [7:0] BUS_DATA;
    logic       BUS_WE;
    logic       BUS_INTERRUPT_RAISE;
    logic       BUS_INTERRUPT_ACK;

    modport master (
        output BUS_ADDR,
        inout  BUS_DATA,
        output BUS_WE,
        input  BUS_INTERRUPT_RAISE,
        output BUS_INTERRUPT_ACK
    );

    modport slave (
        input  BUS_ADDR,
        inout  BUS_DATA,
        input  BUS_WE,
        output BUS_INTERRUPT_RAISE,
        input  BUS_INTERRUPT_ACK
    );
endinterface

// File: rtl/mouse_event_bridge_fifo.sv
// mouse_pkt_fifo
// Synchronous FIFO, WIDTH bits wide, DEPTH entries (power of two).
//   clk, rst_n   clock, async active-low reset
//   push, din    write request and data (ignored when full unless popping)
//   pop          read request (ignored when empty); dout is the current head
//   flush        empties the FIFO; overrides push and pop
//   full, empty, count (0..DEPTH)
//   push_ok      this cycle's push is actually stored
module mouse_pkt_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         push_ok
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_acc;
    logic             push_acc;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_acc  = pop & ~empty;
    // A simultaneous pop frees the slot, so a full FIFO can still accept.
    assign push_acc = push & (~full | pop_acc);
    assign push_ok  = push_acc & ~flush;
    assign dout     = mem[rd_ptr];

    // When full, wr_ptr == rd_ptr: the new packet overwrites the slot being
    // popped this same cycle, which is safe because dout is read before the edge.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_acc && !pop_acc) begin
                count <= count + CNT_W'(1);
            end else if (pop_acc && !push_acc) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mouse_event_bridge.sv
// mouse_event_bridge
// Queues packets from the mouse transceiver and exposes them to a CPU through
// an 8-address register window at BASE_ADDR, with an interrupt on each
// queued packet.
//   CLK, RESET        clock, async active-low reset
//   bus (slave)       CPU bus: address, tristate data, write enable, IRQ/ACK
//   PKT_VALID         one-cycle strobe with PKT_STATUS/PKT_X/PKT_Y
//   PKT_Z             wheel byte, present only with MOUSE_WHEEL_EN defined
// Parameters: BASE_ADDR (window base), FIFO_DEPTH (power of two, 2..16).
module mouse_event_bridge
    import mouse_event_bridge_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR  = 8'hA0,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    mouse_event_bridge_if.slave    bus,
    input  logic                   PKT_VALID,
    input  logic [7:0]             PKT_STATUS,
    input  logic [7:0]             PKT_X,
    input  logic [7:0]             PKT_Y
`ifdef MOUSE_WHEEL_EN
    ,
    input  logic [7:0]             PKT_Z
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);

    logic             sel;
    logic [2:0]       offset;
    logic             rd_req;
    logic             ctrl_wr;
    logic             pop_wr;
    logic             flush;
    logic             overflow;
    pkt_t             pkt_in;
    pkt_t             head;
    pkt_t             head_vis;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             push_ok;
    logic [7:0]       rd_mux;

    logic             irq_en;
    logic             ovf;
    logic             irq;
    logic [7:0]       rd_data;
    logic             rd_oe;

    // 9-bit compare so a window near the top of the address space cannot wrap.
    assign sel     = ({1'b0, bus.BUS_ADDR} >= {1'b0, BASE_ADDR}) &&
                     ({1'b0, bus.BUS_ADDR} <  ({1'b0, BASE_ADDR} + 9'(WINDOW_SIZE)));
    assign offset  = 3'(bus.BUS_ADDR - BASE_ADDR);
    assign rd_req  = sel & ~bus.BUS_WE;
    assign ctrl_wr = sel & bus.BUS_WE & (offset == OFS_CTRL);
    assign pop_wr  = sel & bus.BUS_WE & (offset == OFS_POP);
    assign flush   = ctrl_wr & bus.BUS_DATA[CTRL_FLUSH];
    // A flushed cycle discards the push outright rather than counting a drop.
    assign overflow = PKT_VALID & fifo_full & ~pop_wr & ~flush;

    always_comb begin
        pkt_in        = '0;
        pkt_in.status = PKT_STATUS;
        pkt_in.x      = PKT_X;
        pkt_in.y      = PKT_Y;
`ifdef MOUSE_WHEEL_EN
        pkt_in.z      = PKT_Z;
`endif
    end

    mouse_pkt_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RESET),
        .push    (PKT_VALID),
        .pop     (pop_wr),
        .flush   (flush),
        .din     (pkt_in),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .push_ok (push_ok)
    );

    // Stale FIFO storage must never leak out through the head registers.
    assign head_vis = fifo_empty ? pkt_t'('0) : head;

    always_comb begin
        rd_mux = '0;
        case (offset)
            OFS_STATUS: rd_mux = head_vis.status;
            OFS_X:      rd_mux = head_vis.x;
            OFS_Y:      rd_mux = head_vis.y;
            OFS_LEVEL:  rd_mux = level_byte(ovf, LEVEL_CNT_W'(fifo_count));
            OFS_CTRL:   rd_mux = ctrl_byte(irq_en);
`ifdef MOUSE_WHEEL_EN
            OFS_WHEEL:  rd_mux = head_vis.z;
`endif
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            irq_en  <= 1'b1;
            ovf     <= 1'b0;
            irq     <= 1'b0;
            rd_data <= '0;
            rd_oe   <= 1'b0;
        end else begin
            rd_oe <= rd_req;
            if (rd_req) begin
                rd_data <= rd_mux;
            end
            if (ctrl_wr) begin
                irq_en <= bus.BUS_DATA[CTRL_IRQ_EN];
            end
            // A drop in the same cycle as CLR_OVF keeps the flag set.
            if (overflow) begin
                ovf <= 1'b1;
            end else if (ctrl_wr && bus.BUS_DATA[CTRL_CLR_OVF]) begin
                ovf <= 1'b0;
            end
            // New packet beats a same-cycle acknowledge.
            if (push_ok && irq_en) begin
                irq <= 1'b1;
            end else if (bus.BUS_INTERRUPT_ACK) begin
                irq <= 1'b0;
            end
        end
    end

    assign bus.BUS_DATA            = rd_oe ? rd_data : 8'hzz;
    assign bus.BUS_INTERRUPT_RAISE = irq;

endmodule
